// File: rtl/cordic_pkg.sv
// Shared types and angle tables for the iterative CORDIC rotation stage.
// Angle tables carry 15 fractional bits and are rescaled by the LUT if needed.
package cordic_pkg;

    typedef enum logic [1:0] {
        CS_CIRC = 2'b00,
        CS_LIN  = 2'b01,
        CS_HYP  = 2'b10,
        CS_RSVD = 2'b11
    } coord_sys_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } fsm_state_e;

    localparam int TBL_FRAC = 15;

    // Hyperbolic indices the counter presents twice for convergence.
    localparam logic [5:0] HYP_REPEAT_IDX [3] = '{6'd4, 6'd13, 6'd40};

    // round(atan(2^-i) * 2^15)
    function automatic logic [15:0] atan_tbl(input logic [5:0] i);
        logic [15:0] v;
        case (i)
            6'd0:    v = 16'd25736;
            6'd1:    v = 16'd15193;
            6'd2:    v = 16'd8027;
            6'd3:    v = 16'd4075;
            6'd4:    v = 16'd2045;
            6'd5:    v = 16'd1024;
            6'd6:    v = 16'd512;
            6'd7:    v = 16'd256;
            6'd8:    v = 16'd128;
            6'd9:    v = 16'd64;
            6'd10:   v = 16'd32;
            6'd11:   v = 16'd16;
            6'd12:   v = 16'd8;
            6'd13:   v = 16'd4;
            6'd14:   v = 16'd2;
            6'd15:   v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    // round(atanh(2^-i) * 2^15); entry 0 is never applied
    function automatic logic [15:0] atanh_tbl(input logic [5:0] i);
        logic [15:0] v;
        case (i)
            6'd1:    v = 16'd18000;
            6'd2:    v = 16'd8369;
            6'd3:    v = 16'd4118;
            6'd4:    v = 16'd2051;
            6'd5:    v = 16'd1024;
            6'd6:    v = 16'd512;
            6'd7:    v = 16'd256;
            6'd8:    v = 16'd128;
            6'd9:    v = 16'd64;
            6'd10:   v = 16'd32;
            6'd11:   v = 16'd16;
            6'd12:   v = 16'd8;
            6'd13:   v = 16'd4;
            6'd14:   v = 16'd2;
            6'd15:   v = 16'd1;
            6'd16:   v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_angle_lut.sv
// Z-step constant for one micro-rotation, selected by coordinate system.
// Linear steps are exact powers of two; table entries are rescaled to ZF.
module cordic_angle_lut
    import cordic_pkg::*;
#(
    parameter int W  = 18,
    parameter int ZF = 15
) (
    input  logic [1:0]   coord_sys,
    input  logic [5:0]   iter_idx,
    output logic [W-1:0] z_step
);

    localparam int UP = (ZF >= TBL_FRAC) ? ZF - TBL_FRAC : 0;
    localparam int DN = (ZF <  TBL_FRAC) ? TBL_FRAC - ZF : 0;

    logic [W-1:0] atan_w;
    logic [W-1:0] atanh_w;
    logic [W-1:0] lin_w;

    assign atan_w  = (W'(atan_tbl(iter_idx)) << UP) >> DN;
    assign atanh_w = (W'(atanh_tbl(iter_idx)) << UP) >> DN;
    assign lin_w   = (W'(1) << ZF) >> iter_idx;

    // Reserved encoding falls through to the circular table.
    always_comb begin
        z_step = atan_w;
        unique case (1'b1)
            coord_sys == CS_LIN: z_step = lin_w;
            coord_sys == CS_HYP: z_step = atanh_w;
            default:             z_step = atan_w;
        endcase
    end

endmodule

// File: rtl/cordic_rot_stage.sv
// Iterative CORDIC micro-rotation stage: one shift-add step per valid index,
// drives the iteration counter, handshakes operands in and results out.
module cordic_rot_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int GUARD    = 2,
    parameter int LAST_IDX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       coord_sys,
    input  logic             vec_mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    input  logic [5:0]       iter_idx,
    input  logic             iter_vld,
    output logic             cnt_clr,
    output logic             cnt_en_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             err
);

    localparam int W    = WIDTH + GUARD;
    localparam int FRAC = WIDTH - 3;
    localparam int ZF   = FRAC + GUARD;

    localparam logic signed [W:0] HALF   = (W+1)'(1) << (GUARD - 1);
    localparam logic signed [W:0] SAT_HI = (W+1)'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [W:0] SAT_LO = ~SAT_HI;

    fsm_state_e state_q;
    coord_sys_e cs_q;
    logic       vec_q;

    logic signed [W-1:0] x_q, y_q, z_q;
    logic signed [W-1:0] x_sh, y_sh, z_step;
    logic signed [W-1:0] x_nx, y_nx, z_nx;

    logic d_pos;
    logic is_lin;
    logic is_hyp;
    logic rot_fire;
    logic last_rot;

    // Round half up at the guard boundary, then clamp to the output range.
    function automatic logic [WIDTH-1:0] round_sat(input logic signed [W-1:0] v);
        logic signed [W:0] r;
        r = (W+1)'(v) + HALF;
        r = r >>> GUARD;
        if (r > SAT_HI)
            r = SAT_HI;
        else if (r < SAT_LO)
            r = SAT_LO;
        return r[WIDTH-1:0];
    endfunction

    assign x_sh   = x_q >>> iter_idx;
    assign y_sh   = y_q >>> iter_idx;
    assign d_pos  = vec_q ? y_q[W-1] : ~z_q[W-1];
    assign is_lin = (cs_q == CS_LIN);
    assign is_hyp = (cs_q == CS_HYP);

    // Hyperbolic index 0 diverges, so it is skipped and registers hold.
    assign rot_fire = (state_q == ST_RUN) && iter_vld
                    && !(is_hyp && iter_idx == 6'd0);
    assign last_rot = rot_fire && (iter_idx == 6'(LAST_IDX));

    cordic_angle_lut #(
        .W  (W),
        .ZF (ZF)
    ) u_lut (
        .coord_sys (cs_q),
        .iter_idx  (iter_idx),
        .z_step    (z_step)
    );

    // Next x/y/z for one micro-rotation; sums wrap at W bits.
    always_comb begin
        x_nx = x_q;
        unique case (1'b1)
            is_lin:  x_nx = x_q;
            is_hyp:  x_nx = d_pos ? x_q + y_sh : x_q - y_sh;
            default: x_nx = d_pos ? x_q - y_sh : x_q + y_sh;
        endcase
        y_nx = d_pos ? y_q + x_sh : y_q - x_sh;
        z_nx = d_pos ? z_q - z_step : z_q + z_step;
    end

    // Control FSM with registered handshake/counter outputs and datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            in_ready  <= 1'b1;
            cnt_clr   <= 1'b1;
            cnt_en_n  <= 1'b1;
            out_valid <= 1'b0;
            cs_q      <= CS_CIRC;
            vec_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            err       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q      <= {x_in, {GUARD{1'b0}}};
                        y_q      <= {y_in, {GUARD{1'b0}}};
                        z_q      <= {z_in, {GUARD{1'b0}}};
                        cs_q     <= coord_sys_e'(coord_sys);
                        vec_q    <= vec_mode;
                        err      <= (coord_sys == CS_RSVD);
                        state_q  <= ST_RUN;
                        in_ready <= 1'b0;
                        cnt_clr  <= 1'b0;
                        cnt_en_n <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rot_fire) begin
                        x_q <= x_nx;
                        y_q <= y_nx;
                        z_q <= z_nx;
                    end
                    if (last_rot) begin
                        x_out     <= round_sat(x_nx);
                        y_out     <= round_sat(y_nx);
                        z_out     <= round_sat(z_nx);
                        state_q   <= ST_DONE;
                        out_valid <= 1'b1;
                        cnt_en_n  <= 1'b1;
                        cnt_clr   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q   <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    cnt_clr   <= 1'b1;
                    cnt_en_n  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rot_stage.sv
// Self-checking bench for cordic_rot_stage against a real-arithmetic
// CORDIC reference with directed vectors, random operands and resets.
module tb_cordic_rot_stage;
    import cordic_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  coord_sys = 2'b00;
    logic        vec_mode = 1'b0;
    logic [15:0] x_in = '0, y_in = '0, z_in = '0;
    logic [5:0]  iter_idx = '0;
    logic        iter_vld = 1'b0;
    logic        cnt_clr, cnt_en_n, out_valid;
    logic        out_ready = 1'b0;
    logic signed [15:0] x_out, y_out, z_out;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    int     idx_q[$];
    longint mx, my, mz;
    longint merr;
    longint cx, cy, cz;

    cordic_rot_stage #(
        .WIDTH    (16),
        .GUARD    (2),
        .LAST_IDX (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coord_sys (coord_sys),
        .vec_mode  (vec_mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .iter_idx  (iter_idx),
        .iter_vld  (iter_vld),
        .cnt_clr   (cnt_clr),
        .cnt_en_n  (cnt_en_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs,
                           input longint exp, input longint tol);
        logic ok;
        ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
        n_chk++;
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
        end
    endtask

    function automatic longint wrap18(input longint v);
        longint m;
        m = v & 64'h3FFFF;
        if (m >= 131072) m = m - 262144;
        return m;
    endfunction

    function automatic longint atan_c(input int i);
        real t;
        t = 2.0 ** (-i);
        return longint'($rtoi($atan(t) * 32768.0 + 0.5));
    endfunction

    function automatic longint atanh_c(input int i);
        real t;
        if (i == 0) return 0;
        t = 2.0 ** (-i);
        return longint'($rtoi(0.5 * $ln((1.0 + t) / (1.0 - t)) * 32768.0 + 0.5));
    endfunction

    function automatic longint rsat(input longint v);
        longint r;
        r = (v + 2) >>> 2;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Reference: plain integer CORDIC over the index list, 18-bit wrap.
    task automatic model_op(input int cs, input int vm,
                            input int xi, input int yi, input int zi);
        longint x, y, z, nx, ny, st;
        longint d;
        int i;
        x = longint'(xi) * 4;
        y = longint'(yi) * 4;
        z = longint'(zi) * 4;
        foreach (idx_q[k]) begin
            i = idx_q[k];
            if (!(cs == 2 && i == 0)) begin
                if (vm != 0) d = (y < 0) ? 1 : -1;
                else         d = (z >= 0) ? 1 : -1;
                if (cs == 1)      st = (i > 15) ? 0 : (64'sd1 <<< (15 - i));
                else if (cs == 2) st = atanh_c(i);
                else              st = atan_c(i);
                if (cs == 1)      nx = x;
                else if (cs == 2) nx = x + d * (y >>> i);
                else              nx = x - d * (y >>> i);
                ny = y + d * (x >>> i);
                x = wrap18(nx);
                y = wrap18(ny);
                z = wrap18(z - d * st);
            end
        end
        mx = rsat(x);
        my = rsat(y);
        mz = rsat(z);
        merr = (cs == 3) ? 1 : 0;
    endtask

    task automatic run_op(input int cs, input int vm, input int xi,
                          input int yi, input int zi,
                          input bit gaps, input int hold);
        int cyc;
        model_op(cs, vm, xi, yi, zi);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        chk("cnt_clr_idle", cnt_clr, 1);
        coord_sys = 2'(cs);
        vec_mode  = 1'(vm);
        x_in = 16'(xi);
        y_in = 16'(yi);
        z_in = 16'(zi);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_run", in_ready, 0);
        chk("cnt_en_n_run", cnt_en_n, 0);
        chk("cnt_clr_run", cnt_clr, 0);
        foreach (idx_q[k]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    iter_vld = 1'b0;
                    iter_idx = 6'($urandom);
                    @(negedge clk);
                end
            end
            iter_vld = 1'b1;
            iter_idx = 6'(idx_q[k]);
            @(negedge clk);
        end
        iter_vld = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 4) begin
            @(negedge clk);
            cyc++;
        end
        chk("out_valid", out_valid, 1);
        chk("x_out", x_out, mx);
        chk("y_out", y_out, my);
        chk("z_out", z_out, mz);
        chk("err", err, merr);
        chk("cnt_en_n_done", cnt_en_n, 1);
        chk("cnt_clr_done", cnt_clr, 1);
        cx = x_out;
        cy = y_out;
        cz = z_out;
        out_ready = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_x", x_out, cx);
            chk("hold_y", y_out, cy);
            chk("hold_z", z_out, cz);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    task automatic seq_full();
        idx_q = {};
        for (int i = 0; i < 16; i++) idx_q.push_back(i);
    endtask

    task automatic seq_hyp();
        idx_q = {};
        for (int i = 1; i < 16; i++) begin
            idx_q.push_back(i);
            if (i == int'(HYP_REPEAT_IDX[0]) || i == int'(HYP_REPEAT_IDX[1]))
                idx_q.push_back(i);
        end
    endtask

    initial begin
        longint sx, sy, sz;
        int cs, vm;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cnt_clr", cnt_clr, 1);
        chk("rst_cnt_en_n", cnt_en_n, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x_out", x_out, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;

        seq_full();
        run_op(0, 0, 4975, 0, 6434, 1'b0, 1);
        chk_tol("circ_rot_x", cx, 5793, 3);
        chk_tol("circ_rot_y", cy, 5793, 3);
        sx = cx; sy = cy; sz = cz;

        run_op(0, 1, 8192, 8192, 0, 1'b0, 0);
        chk_tol("circ_vec_z", cz, 6434, 3);
        chk_tol("circ_vec_x", cx, 19078, 4);
        chk_tol("circ_vec_y", cy, 0, 3);

        run_op(1, 0, 4096, 0, 8192, 1'b0, 0);
        chk_tol("lin_rot_y", cy, 4096, 2);
        chk("lin_rot_x", cx, 4096);

        seq_hyp();
        run_op(2, 0, 9892, 0, 4096, 1'b0, 0);
        chk_tol("hyp_rot_x", cx, 9238, 4);
        chk_tol("hyp_rot_y", cy, 4269, 4);

        seq_full();
        run_op(0, 0, 4975, 0, 6434, 1'b1, 5);
        chk("gap_same_x", cx, sx);
        chk("gap_same_y", cy, sy);
        chk("gap_same_z", cz, sz);

        idx_q = {2, 2, 15};
        run_op(1, 0, 1, 32767, 8191, 1'b0, 0);
        chk("sat_y", cy, 32767);

        seq_full();
        run_op(2, 0, 9000, 1500, -3000, 1'b1, 0);

        for (int n = 0; n < 6; n++) begin
            seq_full();
            idx_q.insert($urandom_range(0, 15), int'($urandom_range(16, 40)));
            cs = int'($urandom_range(0, 2));
            vm = int'($urandom_range(0, 1));
            run_op(cs, vm,
                   int'($urandom_range(0, 12000)) - 6000,
                   int'($urandom_range(0, 12000)) - 6000,
                   int'($urandom_range(0, 12000)) - 6000,
                   1'($urandom), 2);
        end

        seq_full();
        run_op(3, 0, 3000, -2000, 4000, 1'b0, 0);

        idx_q = {};
        for (int i = 0; i < 8; i++) idx_q.push_back(i);
        @(negedge clk);
        coord_sys = 2'd0;
        vec_mode  = 1'b0;
        x_in = 16'd3000;
        y_in = 16'd1000;
        z_in = 16'd2000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        foreach (idx_q[k]) begin
            iter_vld = 1'b1;
            iter_idx = 6'(idx_q[k]);
            @(negedge clk);
        end
        iter_vld = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_cnt_clr", cnt_clr, 1);
        chk("mid_rst_cnt_en_n", cnt_en_n, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_x_out", x_out, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;

        seq_full();
        run_op(3, 1, 5000, 3000, 0, 1'b0, 0);
        run_op(0, 0, -4000, 2500, -5000, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
